// File: rtl/frame_rd_sched.sv
// frame_rd_sched: sequences AXI master burst reads of an RGB565 frame buffer.
// One read command is issued per burst whenever the downstream converter signals
// ready_to_rd. The block walks burst addresses, counts bursts per line and per
// frame, pulses line_done / frame_done, and holds a sticky bus-error flag.
// Optional build macro FRAME_LOOP_EN: after a clean frame the block restarts at
// the latched frame_base without another start (continuous streaming).
module frame_rd_sched #(
  parameter int HRES   = 640,
  parameter int VRES   = 480,
  parameter int BURST  = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              ready_to_rd,
  input  logic [11:0]       mst_length,
  input  logic              cmdack,
  input  logic              cmplt,
  input  logic              error,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [11:0]       rd_length,
  output logic              busy,
  output logic              line_done,
  output logic              frame_done,
  output logic              err_flag,
  output logic [15:0]       burst_idx
);

  // Bursts per line and per frame
  localparam int BPL = (HRES * 2) / BURST;
  localparam int BPF = BPL * VRES;

  localparam logic [15:0]       LAST_LINE  = 16'(BPL - 1);
  localparam logic [15:0]       LAST_BURST = 16'(BPF - 1);
  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST);

  // Elaboration-time sanity checks on the geometry
  generate
    if (((HRES * 2) % BURST) != 0) begin : g_bad_burst
      $error("frame_rd_sched: HRES*2 must be a multiple of BURST");
    end
    if (BPL < 1) begin : g_bad_bpl
      $error("frame_rd_sched: a line must contain at least one burst");
    end
    if (BPF > 65535) begin : g_bad_bpf
      $error("frame_rd_sched: bursts per frame exceed burst_idx range");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REQ,
    XFER
  } state_t;

  state_t      state;
  logic [15:0] line_cnt;

`ifdef FRAME_LOOP_EN
  logic [ADDR_W-1:0] base_q;
`endif

  // Command sequencer: one outstanding burst, registered outputs and pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      rd_length  <= '0;
      busy       <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      err_flag   <= 1'b0;
      burst_idx  <= '0;
      line_cnt   <= '0;
`ifdef FRAME_LOOP_EN
      base_q     <= '0;
`endif
    end else begin
      line_done  <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          busy   <= 1'b0;
          rd_req <= 1'b0;
          if (start) begin
            rd_addr   <= frame_base;
            burst_idx <= '0;
            line_cnt  <= '0;
            err_flag  <= 1'b0;
            busy      <= 1'b1;
`ifdef FRAME_LOOP_EN
            base_q    <= frame_base;
`endif
            state     <= WAIT;
          end
        end

        WAIT: begin
          if (ready_to_rd) begin
            rd_req    <= 1'b1;
            rd_length <= mst_length;
            state     <= REQ;
          end
        end

        REQ: begin
          if (cmdack) begin
            rd_req <= 1'b0;
            state  <= XFER;
          end
        end

        XFER: begin
          if (cmplt) begin
            if (error) begin
              err_flag <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              rd_addr   <= rd_addr + BURST_STEP;
              burst_idx <= burst_idx + 16'd1;

              if (line_cnt == LAST_LINE) begin
                line_cnt  <= '0;
                line_done <= 1'b1;
              end else begin
                line_cnt <= line_cnt + 16'd1;
              end

              if (burst_idx == LAST_BURST) begin
                frame_done <= 1'b1;
`ifdef FRAME_LOOP_EN
                // Later assignments override the per-burst advance above
                rd_addr   <= base_q;
                burst_idx <= '0;
                line_cnt  <= '0;
                state     <= WAIT;
`else
                busy      <= 1'b0;
                state     <= IDLE;
`endif
              end else begin
                state <= WAIT;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_rd_sched.sv
// Testbench for frame_rd_sched: a cycle table on a default-size instance, then
// randomized frames on a small instance (HRES=8, VRES=2, BURST=8) checked
// against expected values computed from burst counts and address arithmetic.
module tb_frame_rd_sched;

  logic        clk = 1'b0;
  logic        rst_n, start, ready_to_rd, cmdack, cmplt, error;
  logic [31:0] frame_base;
  logic [11:0] mst_length;

  logic        d_req, d_busy, d_ld, d_fd, d_err;
  logic [31:0] d_addr;
  logic [11:0] d_len;
  logic [15:0] d_idx;

  logic        s_req, s_busy, s_ld, s_fd, s_err;
  logic [31:0] s_addr;
  logic [11:0] s_len;
  logic [15:0] s_idx;

  // Selected DUT outputs
  logic        sel;
  logic        o_req, o_busy, o_ld, o_fd, o_err;
  logic [31:0] o_addr;
  logic [11:0] o_len;
  logic [15:0] o_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  frame_rd_sched #(.HRES(640), .VRES(480), .BURST(128), .ADDR_W(32)) u_def (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_base(frame_base),
    .ready_to_rd(ready_to_rd), .mst_length(mst_length), .cmdack(cmdack),
    .cmplt(cmplt), .error(error), .rd_req(d_req), .rd_addr(d_addr),
    .rd_length(d_len), .busy(d_busy), .line_done(d_ld), .frame_done(d_fd),
    .err_flag(d_err), .burst_idx(d_idx)
  );

  frame_rd_sched #(.HRES(8), .VRES(2), .BURST(8), .ADDR_W(32)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_base(frame_base),
    .ready_to_rd(ready_to_rd), .mst_length(mst_length), .cmdack(cmdack),
    .cmplt(cmplt), .error(error), .rd_req(s_req), .rd_addr(s_addr),
    .rd_length(s_len), .busy(s_busy), .line_done(s_ld), .frame_done(s_fd),
    .err_flag(s_err), .burst_idx(s_idx)
  );

  always_comb begin
    o_req  = sel ? s_req  : d_req;
    o_busy = sel ? s_busy : d_busy;
    o_ld   = sel ? s_ld   : d_ld;
    o_fd   = sel ? s_fd   : d_fd;
    o_err  = sel ? s_err  : d_err;
    o_addr = sel ? s_addr : d_addr;
    o_len  = sel ? s_len  : d_len;
    o_idx  = sel ? s_idx  : d_idx;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rst_n, start, rdy, ack, cmp;
    logic        req, busy;
    logic [31:0] addr;
    logic [11:0] len;
    logic [15:0] idx;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic rd, input logic a,
                              input logic c, input logic q, input logic b,
                              input logic [31:0] ad, input logic [11:0] l, input logic [15:0] i);
    vec_t v;
    v.rst_n = r; v.start = s; v.rdy = rd; v.ack = a; v.cmp = c;
    v.req = q; v.busy = b; v.addr = ad; v.len = l; v.idx = i;
    return v;
  endfunction

  // One frame (or its first nb bursts) with randomized bus timing.
  // err_at: burst index that completes with error, or -1 for none.
  task automatic run_bursts(input logic use_small, input logic [31:0] base, input int nb,
                            input int bpl, input int bpf, input int burst,
                            input int err_at, input int first_gap);
    logic [31:0] exp_addr;
    logic [11:0] l;
    int          cnt;
    sel        = use_small;
    frame_base = base;
    start      = 1'b1;
    step();
    start      = 1'b0;
    frame_base = $urandom;
    chk("start_busy", o_busy, 1);
    chk("start_addr", o_addr, base);
    chk("start_idx", o_idx, 0);
    chk("start_err_clr", o_err, 0);
    for (int k = 0; k < nb; k++) begin
      exp_addr = base + 32'(k) * 32'(burst);
      ready_to_rd = 1'b0;
      for (int g = 0; g < ((k == 0) ? first_gap : int'($urandom_range(0, 3))); g++) begin
        step();
        chk("backpressure_no_req", o_req, 0);
      end
      l = 12'($urandom_range(1, 4095));
      mst_length  = l;
      ready_to_rd = 1'b1;
      step();
      ready_to_rd = 1'b0;
      mst_length  = 12'($urandom);
      chk("req_latency", o_req, 1);
      chk("req_addr", o_addr, exp_addr);
      chk("req_len", o_len, l);
      repeat ($urandom_range(0, 3)) begin
        step();
        chk("req_hold", o_req, 1);
        chk("req_addr_hold", o_addr, exp_addr);
      end
      cmdack = 1'b1;
      step();
      cmdack = 1'b0;
      chk("req_drop", o_req, 0);
      repeat ($urandom_range(0, 3)) begin
        step();
        chk("xfer_idx_wait", o_idx, 16'(k));
      end
      cmplt = 1'b1;
      error = (k == err_at);
      start = (k == bpf - 1);
      step();
      cmplt = 1'b0;
      error = 1'b0;
      start = 1'b0;
      if (k == err_at) begin
        chk("err_flag", o_err, 1);
        chk("err_busy", o_busy, 0);
        chk("err_no_fd", o_fd, 0);
        chk("err_idx", o_idx, 16'(k));
        step();
        chk("err_idle", o_busy, 0);
        chk("err_sticky", o_err, 1);
        return;
      end
      cnt = k + 1;
      chk("line_done", o_ld, ((cnt % bpl) == 0));
      chk("frame_done", o_fd, (cnt == bpf));
      if (cnt == bpf) begin
`ifdef FRAME_LOOP_EN
        chk("loop_busy", o_busy, 1);
        chk("loop_addr", o_addr, base);
        chk("loop_idx", o_idx, 0);
`else
        chk("end_busy", o_busy, 0);
        chk("end_idx", o_idx, 16'(cnt));
`endif
      end else begin
        chk("burst_idx", o_idx, 16'(cnt));
        chk("next_addr", o_addr, base + 32'(cnt) * 32'(burst));
        chk("mid_busy", o_busy, 1);
      end
      step();
      chk("ld_width", o_ld, 0);
      chk("fd_width", o_fd, 0);
      if (cnt == bpf) begin
`ifdef FRAME_LOOP_EN
        ready_to_rd = 1'b1;
        step();
        ready_to_rd = 1'b0;
        chk("loop_req", o_req, 1);
        chk("loop_req_addr", o_addr, base);
        do_reset();
`else
        chk("start_with_last_ignored", o_busy, 0);
`endif
      end
    end
  endtask

  vec_t tbl[16];

  initial begin
    rst_n = 1'b0; start = 1'b0; ready_to_rd = 1'b0; cmdack = 1'b0;
    cmplt = 1'b0; error = 1'b0; frame_base = 32'h1000_0000; mst_length = 12'd128;
    sel = 1'b0;

    //          rst st rdy ack cmp   req busy addr          len  idx
    tbl[0]  = mk(0, 0, 0, 0, 0,   0, 0, 32'h0,          0,   0);
    tbl[1]  = mk(0, 0, 1, 0, 0,   0, 0, 32'h0,          0,   0);
    tbl[2]  = mk(1, 0, 1, 0, 0,   0, 0, 32'h0,          0,   0);
    tbl[3]  = mk(1, 0, 1, 0, 0,   0, 0, 32'h0,          0,   0);
    tbl[4]  = mk(1, 1, 1, 0, 0,   0, 1, 32'h1000_0000,  0,   0);
    tbl[5]  = mk(1, 0, 1, 0, 0,   1, 1, 32'h1000_0000,  128, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0,   1, 1, 32'h1000_0000,  128, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0,   1, 1, 32'h1000_0000,  128, 0);
    tbl[8]  = mk(1, 0, 0, 1, 0,   0, 1, 32'h1000_0000,  128, 0);
    tbl[9]  = mk(1, 0, 0, 0, 1,   0, 1, 32'h1000_0080,  128, 1);
    tbl[10] = mk(1, 1, 0, 0, 0,   0, 1, 32'h1000_0080,  128, 1);
    tbl[11] = mk(1, 0, 1, 0, 0,   1, 1, 32'h1000_0080,  128, 1);
    tbl[12] = mk(1, 0, 0, 1, 0,   0, 1, 32'h1000_0080,  128, 1);
    tbl[13] = mk(0, 0, 0, 0, 0,   0, 0, 32'h0,          0,   0);
    tbl[14] = mk(1, 0, 0, 0, 1,   0, 0, 32'h0,          0,   0);
    tbl[15] = mk(1, 0, 1, 1, 1,   0, 0, 32'h0,          0,   0);

    for (int i = 0; i < 16; i++) begin
      rst_n = tbl[i].rst_n; start = tbl[i].start; ready_to_rd = tbl[i].rdy;
      cmdack = tbl[i].ack; cmplt = tbl[i].cmp;
      step();
      chk($sformatf("tbl%0d_req", i), d_req, tbl[i].req);
      chk($sformatf("tbl%0d_busy", i), d_busy, tbl[i].busy);
      chk($sformatf("tbl%0d_addr", i), d_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_len", i), d_len, tbl[i].len);
      chk($sformatf("tbl%0d_idx", i), d_idx, tbl[i].idx);
      chk($sformatf("tbl%0d_ld", i), d_ld, 0);
    end
    start = 1'b0; ready_to_rd = 1'b0; cmdack = 1'b0; cmplt = 1'b0;

    // Default geometry: one full line of 10 bursts after 20 idle cycles
    run_bursts(1'b0, 32'h2000_0000, 10, 10, 4800, 128, -1, 20);
    chk("line_end_idx", d_idx, 10);
    chk("line_end_addr", d_addr, 32'h2000_0500);
    do_reset();

    // Small geometry: full frame, error on burst 2, then address wrap
    run_bursts(1'b1, 32'h3000_0000, 4, 2, 4, 8, -1, 2);
    run_bursts(1'b1, 32'h4000_0000, 4, 2, 4, 8, 1, 20);
    run_bursts(1'b1, 32'hFFFF_FFF0, 4, 2, 4, 8, -1, 0);

    for (int r = 0; r < 8; r++) begin
      int e;
      e = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_bursts(1'b1, $urandom & 32'hFFFF_FFF8, 4, 2, 4, 8, e, int'($urandom_range(0, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
